control_acceso_parqueo: RTL

Parking-entry access controller; consumes the sensor and PIN stimulus produced by the parking bench/keypad front end, and drives the gate and the two alarm outputs.
- Moore FSM tracks vehicle arrival, PIN attempts, gate opening, vehicle passage and tailgating/blocking events.
- Counts consecutive wrong PINs and raises a PIN alarm at the limit.
- Sits directly downstream of the stimulus/keypad stage and directly upstream of the gate actuator.

---
 rtl/control_acceso_pkg.sv | 22 ++
 rtl/control_acceso_parqueo_detector_flancos.sv | 20 ++
 rtl/control_acceso_parqueo.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/control_acceso_pkg.sv
// Shared types and widths for the parking-entry access controller.
// Holds the FSM state encoding and the saturating attempt-counter increment.
package control_acceso_pkg;

  localparam int ANCHO_CLAVE    = 16;
  localparam int ANCHO_INTENTOS = 3;

  typedef enum logic [2:0] {
    ESPERA,
    ESPERA_PIN,
    COMPUERTA_ABIERTA,
    ALARMA_PIN,
    BLOQUEO
  } estado_t;

  localparam logic [ANCHO_INTENTOS-1:0] INTENTOS_SAT = '1;

  function automatic logic [ANCHO_INTENTOS-1:0] incr_sat(input logic [ANCHO_INTENTOS-1:0] valor);
    return (valor == INTENTOS_SAT) ? valor : valor + 1'b1;
  endfunction

endpackage

// File: rtl/control_acceso_parqueo_detector_flancos.sv
// Rise/fall detector: registers the previous sample; edges are valid in the cycle the input changes.
// Latency: edge flags are combinational from input and registered previous value; no backpressure.
module detector_flancos (
  input  logic clock,
  input  logic reset,
  input  logic senal,
  output logic previo,
  output logic subida,
  output logic bajada
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) previo <= 1'b0;
    else       previo <= senal;
  end

  assign subida = senal & ~previo;
  assign bajada = ~senal & previo;

endmodule

// File: rtl/control_acceso_parqueo.sv
// Parking-entry gate/PIN/tailgating Moore controller; TIMEOUT_COMPUERTA_EN adds a gate-open timeout.
// Latency: inputs sampled at edge N appear on the registered outputs right after edge N; no backpressure.
module control_acceso_parqueo
  import control_acceso_pkg::*;
#(
  parameter logic [ANCHO_CLAVE-1:0] CLAVE_CORRECTA = 16'h3257,
  parameter int                     MAX_INTENTOS   = 3,
  parameter int                     TIMEOUT_CICLOS = 100
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      sensor_llegada_vehiculo,
  input  logic                      sensor_ingreso_vehiculo,
  input  logic [ANCHO_CLAVE-1:0]    clave_ingresada,
  input  logic                      clave_valida,
  output logic                      senal_compuerta,
  output logic                      senal_alarma_pin,
  output logic                      senal_alarma_bloqueo,
  output logic [ANCHO_INTENTOS-1:0] intentos_fallidos
);

  estado_t                   estado, estado_sig;
  logic [ANCHO_INTENTOS-1:0] intentos_sig;
  logic                      llegada_q, llegada_sube, llegada_baja;
  logic                      ingreso_q, ingreso_sube, ingreso_baja;
  logic                      clave_ok, clave_mal;
  logic                      tiempo_agotado;
  logic                      unused_flancos;

  detector_flancos u_det_llegada (
    .clock  (clock),
    .reset  (reset),
    .senal  (sensor_llegada_vehiculo),
    .previo (llegada_q),
    .subida (llegada_sube),
    .bajada (llegada_baja)
  );

  detector_flancos u_det_ingreso (
    .clock  (clock),
    .reset  (reset),
    .senal  (sensor_ingreso_vehiculo),
    .previo (ingreso_q),
    .subida (ingreso_sube),
    .bajada (ingreso_baja)
  );

  assign unused_flancos = llegada_q ^ llegada_baja ^ ingreso_q ^ ingreso_sube;

  assign clave_ok  = clave_valida && (clave_ingresada == CLAVE_CORRECTA);
  assign clave_mal = clave_valida && (clave_ingresada != CLAVE_CORRECTA);

`ifdef TIMEOUT_COMPUERTA_EN
  localparam int ANCHO_TIMER = $clog2(TIMEOUT_CICLOS + 1);
  logic [ANCHO_TIMER-1:0] timer;
  logic                   timer_activo;

  // A vehicle starting to cross wins over a timer expiring in the same cycle.
  assign tiempo_agotado = timer_activo && (timer == ANCHO_TIMER'(1)) && !ingreso_sube;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer        <= '0;
      timer_activo <= 1'b0;
    end else if (estado_sig == COMPUERTA_ABIERTA && estado != COMPUERTA_ABIERTA) begin
      timer        <= ANCHO_TIMER'(TIMEOUT_CICLOS);
      timer_activo <= 1'b1;
    end else if (estado == COMPUERTA_ABIERTA) begin
      if (ingreso_sube)
        timer_activo <= 1'b0;
      else if (timer_activo && timer != '0)
        timer <= timer - 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CICLOS;
  assign tiempo_agotado = 1'b0;
`endif

  always_comb begin
    estado_sig   = estado;
    intentos_sig = intentos_fallidos;
    case (estado)
      ESPERA: begin
        if (sensor_ingreso_vehiculo)      estado_sig = BLOQUEO;
        else if (sensor_llegada_vehiculo) estado_sig = ESPERA_PIN;
      end
      ESPERA_PIN: begin
        if (sensor_llegada_vehiculo && sensor_ingreso_vehiculo) begin
          estado_sig = BLOQUEO;
        end else if (clave_ok) begin
          estado_sig   = COMPUERTA_ABIERTA;
          intentos_sig = '0;
        end else if (clave_mal) begin
          intentos_sig = incr_sat(intentos_fallidos);
          if (intentos_sig >= ANCHO_INTENTOS'(MAX_INTENTOS)) estado_sig = ALARMA_PIN;
        end else if (!sensor_llegada_vehiculo) begin
          estado_sig = ESPERA;
        end
      end
      ALARMA_PIN: begin
        if (sensor_ingreso_vehiculo) begin
          estado_sig = BLOQUEO;
        end else if (clave_ok) begin
          estado_sig   = COMPUERTA_ABIERTA;
          intentos_sig = '0;
        end else if (clave_mal) begin
          intentos_sig = incr_sat(intentos_fallidos);
        end
      end
      COMPUERTA_ABIERTA: begin
        if (ingreso_baja)                                      estado_sig = ESPERA;
        else if (llegada_sube && sensor_ingreso_vehiculo)      estado_sig = BLOQUEO;
        else if (tiempo_agotado)                               estado_sig = ESPERA;
      end
      BLOQUEO: begin
        if (clave_ok) begin
          estado_sig   = ESPERA;
          intentos_sig = '0;
        end
      end
      default: estado_sig = ESPERA;
    endcase
  end

  // Outputs are decoded from the next state so they are flops, not glitchy decode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado               <= ESPERA;
      intentos_fallidos    <= '0;
      senal_compuerta      <= 1'b0;
      senal_alarma_pin     <= 1'b0;
      senal_alarma_bloqueo <= 1'b0;
    end else begin
      estado               <= estado_sig;
      intentos_fallidos    <= intentos_sig;
      senal_compuerta      <= (estado_sig == COMPUERTA_ABIERTA);
      senal_alarma_pin     <= (estado_sig == ALARMA_PIN);
      senal_alarma_bloqueo <= (estado_sig == BLOQUEO);
    end
  end

endmodule
